// File: rtl/canvas_pkg.sv
// canvas_pkg: shared types, canvas geometry and clipping helper for the write sequencer
package canvas_pkg;
  localparam int CANVAS_W = 200;
  localparam int CANVAS_H = 200;
  localparam int MAX_RADIUS = 3;
  localparam int COLOR_W = 3;
  localparam int COORD_W = 8;
  localparam int SW = 10;
  typedef logic signed [SW-1:0] scoord_t;
  localparam scoord_t W_S = scoord_t'(CANVAS_W);
  localparam scoord_t H_S = scoord_t'(CANVAS_H);
  localparam scoord_t ONE_S = scoord_t'(1);
  typedef enum logic {CMD_PAINT, CMD_CLEAR} cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PAINT, ST_CLEAR} seq_state_t;
  function automatic logic on_canvas(scoord_t x, scoord_t y);
    return !x[SW-1] && !y[SW-1] && x < W_S && y < H_S;
  endfunction
endpackage

// File: rtl/sweep_counter.sv
// sweep_counter: raster x/y counter with programmable signed bounds; exposes next position
module sweep_counter
  import canvas_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    load,
  input  logic    en,
  input  scoord_t xs,
  input  scoord_t xe,
  input  scoord_t ys,
  input  scoord_t ye,
  output scoord_t nx,
  output scoord_t ny,
  output logic    step,
  output logic    wrap,
  output logic    last
);
  scoord_t x_q, y_q, xs_q, xe_q, ye_q;
  scoord_t x_d, y_d, xs_d, xe_d, ye_d;
  logic adv;
  always_comb begin
    wrap = x_q == xe_q;
    last = wrap && y_q == ye_q;
    adv = en && !last;
    step = load || adv;
    x_d = load ? xs : adv ? (wrap ? xs_q : x_q + ONE_S) : x_q;
    y_d = load ? ys : (adv && wrap) ? y_q + ONE_S : y_q;
    xs_d = load ? xs : xs_q;
    xe_d = load ? xe : xe_q;
    ye_d = load ? ye : ye_q;
    nx = x_d;
    ny = y_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      xs_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      xs_q <= xs_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
    end
  end
endmodule

// File: rtl/canvas_write_sequencer.sv
// canvas_write_sequencer: expands paint/clear commands into clipped one-pixel-per-clock write strobes
module canvas_write_sequencer
  import canvas_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_cmd,
  input  logic [COORD_W-1:0]                req_x,
  input  logic [COORD_W-1:0]                req_y,
  input  logic [$clog2(MAX_RADIUS+1)-1:0]   req_size,
  input  logic [COLOR_W-1:0]                req_color,
  output logic                              brush,
  output logic [COORD_W-1:0]                wx,
  output logic [COORD_W-1:0]                wy,
  output logic [COLOR_W-1:0]                newColor,
  output logic                              busy,
  output logic                              done
);
  seq_state_t state_q, state_d;
  logic brush_q, brush_d, busy_q, busy_d, done_q, done_d;
  logic [COORD_W-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic accept, run, clr, step, wrap, last;
  scoord_t cx, cy, r, xs, xe, ys, ye, nx, ny;
  sweep_counter u_sweep (
    .clk(clk), .reset_n(reset_n), .load(accept), .en(run),
    .xs(xs), .xe(xe), .ys(ys), .ye(ye),
    .nx(nx), .ny(ny), .step(step), .wrap(wrap), .last(last)
  );
  // Outputs register the counter's next position so the first strobe lands right after accept.
  always_comb begin
    accept = req_valid && state_q == ST_IDLE;
    run = state_q != ST_IDLE;
    clr = cmd_t'(req_cmd) == CMD_CLEAR;
    cx = scoord_t'(req_x);
    cy = scoord_t'(req_y);
    r = scoord_t'(req_size);
    xs = clr ? '0 : cx - r;
    xe = clr ? W_S - ONE_S : cx + r;
    ys = clr ? '0 : cy - r;
    ye = clr ? H_S - ONE_S : cy + r;
    state_d = accept ? (clr ? ST_CLEAR : ST_PAINT) : (run && last) ? ST_IDLE : state_q;
    brush_d = step && on_canvas(nx, ny);
    wx_d = brush_d ? nx[COORD_W-1:0] : wx_q;
    wy_d = brush_d ? ny[COORD_W-1:0] : wy_q;
    color_d = accept ? req_color : color_q;
    busy_d = step;
    done_d = run && last;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      brush_q <= 1'b0;
      wx_q <= '0;
      wy_q <= '0;
      color_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      brush_q <= brush_d;
      wx_q <= wx_d;
      wy_q <= wy_d;
      color_q <= color_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign brush = brush_q;
  assign wx = wx_q;
  assign wy = wy_q;
  assign newColor = color_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_canvas_write_sequencer.sv
// tb_canvas_write_sequencer: directed and random commands checked against a raster/clipping reference model
module tb_canvas_write_sequencer;
  logic clk = 0, reset_n = 0, req_valid = 0, req_cmd = 0;
  logic [7:0] req_x = 0, req_y = 0;
  logic [1:0] req_size = 0;
  logic [2:0] req_color = 0;
  logic req_ready, brush, busy, done;
  logic [7:0] wx, wy;
  logic [2:0] newColor;
  int errors = 0, checks = 0;
  int ewx = 0, ewy = 0;
  int w;
  canvas_write_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_x(req_x), .req_y(req_y), .req_size(req_size),
    .req_color(req_color), .brush(brush), .wx(wx), .wy(wy), .newColor(newColor),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(bit v, bit c, int x, int y, int r, int col);
    req_valid = v;
    req_cmd = c;
    req_x = 8'(x);
    req_y = 8'(y);
    req_size = 2'(r);
    req_color = 3'(col);
  endtask
  task automatic issue(bit c, int x, int y, int r, int col);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    drive(1, c, x, y, r, col);
  endtask
  function automatic int span(int c, int r, int lim);
    int lo = (c - r < 0) ? 0 : c - r;
    int hi = (c + r > lim - 1) ? lim - 1 : c + r;
    return (hi < lo) ? 0 : hi - lo + 1;
  endfunction
  task automatic sweep(string tag, int xs, int xe, int ys, int ye, int col,
                       bit nv, bit nc, int nxp, int nyp, int nr, int ncol, output int writes);
    int k = 0;
    writes = 0;
    for (int yy = ys; yy <= ye; yy++)
      for (int xx = xs; xx <= xe; xx++) begin
        bit vis;
        @(negedge clk);
        if (k == 0) drive(nv, nc, nxp, nyp, nr, ncol);
        k++;
        vis = xx >= 0 && xx < 200 && yy >= 0 && yy < 200;
        if (vis) begin
          ewx = xx;
          ewy = yy;
        end
        writes += int'(brush);
        chk(tag, 32'({brush, wx, wy, newColor, busy, done, req_ready}),
            32'({vis, 8'(ewx), 8'(ewy), 3'(col), 1'b1, 1'b0, 1'b0}));
      end
    @(negedge clk);
    chk({tag, "_done"}, 32'({brush, busy, done, req_ready, newColor}),
        32'({1'b0, 1'b0, 1'b1, 1'b1, 3'(col)}));
  endtask
  task automatic paint(string tag, int x, int y, int r, int col);
    issue(0, x, y, r, col);
    sweep(tag, x - r, x + r, y - r, y + r, col, 0, 0, 0, 0, 0, 0, w);
    chk({tag, "_writes"}, 32'(w), 32'(span(x, r, 200) * span(y, r, 200)));
  endtask
  initial begin
    #12;
    chk("reset_outs", 32'({brush, wx, wy, newColor, busy, done}), 32'd0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("post_reset", 32'({req_ready, brush, busy, done}), 32'b1000);
    paint("p10", 10, 10, 1, 5);
    paint("p00", 0, 0, 2, 3);
    paint("p199", 199, 199, 3, 6);
    paint("p250", 250, 10, 0, 1);
    for (int i = 0; i < 8; i++)
      paint("prand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    issue(1, 77, 88, 3, 0);
    sweep("clr", 0, 199, 0, 199, 0, 1, 0, 20, 30, 1, 7, w);
    chk("clr_writes", 32'(w), 32'd40000);
    sweep("clr_next", 19, 21, 29, 31, 7, 0, 0, 0, 0, 0, 0, w);
    chk("clr_next_writes", 32'(w), 32'd9);
    issue(0, 5, 6, 0, 2);
    sweep("b2b_a", 5, 5, 6, 6, 2, 1, 0, 7, 8, 0, 4, w);
    sweep("b2b_b", 7, 7, 8, 8, 4, 0, 0, 0, 0, 0, 0, w);
    chk("b2b_b_writes", 32'(w), 32'd1);
    issue(1, 0, 0, 0, 1);
    w = 0;
    for (int k = 0; k < 1234; k++) begin
      @(negedge clk);
      if (k == 0) drive(0, 0, 0, 0, 0, 0);
      w += int'(brush);
    end
    chk("rst_pre_writes", 32'(w), 32'd1234);
    #2 reset_n = 0;
    #1 chk("rst_async", 32'({brush, busy, done, wx, wy, newColor}), 32'd0);
    ewx = 0;
    ewy = 0;
    @(negedge clk);
    reset_n = 1;
    w = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      w += int'(brush) + int'(busy) + int'(!req_ready);
    end
    chk("rst_quiet", 32'(w), 32'd0);
    paint("p_after_rst", 3, 3, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/canvas_write_sequencer.md
Name: canvas_write_sequencer

Overview:
- Sole write-port master for the pixel frame store.
- Accepts brush and clear commands from the command decoder over a valid/ready handshake.
- Expands each command into a stream of single-pixel write strobes (brush, wx, wy, newColor), one pixel per clock.
- Clips the stream to the visible canvas; the VGA read path is untouched.

Parameters:
- CANVAS_W, 200: visible canvas width in pixels; valid x is 0..CANVAS_W-1.
- CANVAS_H, 200: visible canvas height in pixels; valid y is 0..CANVAS_H-1.
- MAX_RADIUS, 3: largest brush radius accepted; the req_size field is 2 bits.
- COLOR_W, 3: colour code width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  sequencer can accept a command.
- req_cmd  in  1  0 = PAINT, 1 = CLEAR.
- req_x  in  8  brush centre x (PAINT only).
- req_y  in  8  brush centre y (PAINT only).
- req_size  in  2  brush radius r; square side is 2r+1 (PAINT only).
- req_color  in  COLOR_W  colour to write.
- brush  out  1  write strobe to the frame store.
- wx  out  8  write x.
- wy  out  8  write y.
- newColor  out  COLOR_W  write colour.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, brush=0, wx=wy=0, newColor=0, busy=0, done=0, req_ready=1 once out of reset.
  - Any in-flight command is abandoned; no further strobes are issued.
- Handshake:
  - req_ready=1 only in IDLE.
  - A command is accepted on a rising edge with req_valid&&req_ready; all req_* fields are latched on that edge.
  - req_valid while busy is ignored; the requester must hold it.
- States: IDLE, PAINT, CLEAR.
  - IDLE -> PAINT or CLEAR on accept.
  - PAINT/CLEAR -> IDLE after the last sweep step.
- PAINT sweep:
  - Offsets dy from -r to +r (outer), dx from -r to +r (inner), raster order; exactly (2r+1)^2 step cycles.
  - Candidate coordinate: cx=req_x+dx, cy=req_y+dy, computed as 10-bit signed.
  - brush=1 for a step only if 0<=cx<CANVAS_W and 0<=cy<CANVAS_H; otherwise brush=0 and wx/wy hold their previous value.
  - A centre outside the canvas is legal and is simply clipped.
- CLEAR sweep:
  - y from 0 to CANVAS_H-1 (outer), x from 0 to CANVAS_W-1 (inner).
  - brush=1 every step; exactly CANVAS_W*CANVAS_H cycles.
  - req_x, req_y and req_size are ignored.
- Timing:
  - Outputs are registered.
  - The first step's strobe is visible in the cycle after the accept edge.
  - One pixel per cycle, no bubbles.
- Completion:
  - In the cycle after the last step: state=IDLE, brush=0, done=1 for exactly one cycle, busy=0, req_ready=1.
  - A new command may be accepted on that same cycle's edge (back-to-back).
- busy=1 from the accept edge through the last step.
- newColor holds the latched colour for the whole command and keeps its value in IDLE.

Decomposition:
- Package canvas_pkg:
  - typedef enum cmd_t {PAINT, CLEAR};
  - typedef enum seq_state_t {IDLE, PAINT, CLEAR};
  - localparams CANVAS_W, CANVAS_H, MAX_RADIUS, COLOR_W, COORD_W=8.
- Sub-module sweep_counter:
  - Nested x/y counter with programmable start and end per axis, signed 10-bit.
  - Signals step, last and wrap.
  - Reused for both the PAINT and CLEAR sweeps.

Test Plan:
- PAINT at (10,10), r=1, color 5:
  - 9 strobes at (9,9),(10,9),(11,9),(9,10)..(11,11), in that order, newColor=5.
  - done pulses at cycle 10 after accept.
- PAINT at (0,0), r=2, color 3:
  - 25 step cycles with only 9 strobes, covering x,y in 0..2.
  - No strobe with negative or wrapped coordinates; done at cycle 26.
- PAINT at (199,199), r=3:
  - 49 cycles; strobes only for x,y in 196..199, i.e. 16 writes.
  - PAINT at (250,10), r=0 produces 0 strobes and done at cycle 2.
- CLEAR, color 0:
  - 40000 consecutive strobes, with the last at (199,199).
  - req_ready stays 0 throughout while req_valid is held high with a second command.
  - The second command is accepted on the done cycle.
- Reset mid-operation:
  - Pull reset_n low at step 1234 of a CLEAR; brush drops immediately and state=IDLE.
  - After release, no strobes occur until a new command is accepted.
- Back-to-back:
  - Two PAINT r=0 commands presented continuously.
  - Strobes appear on cycles 1 and 3 after the first accept; the second accept occurs on the first done cycle.
